// File: rtl/burst_shift_register_pkg.sv
// Shared encodings for the burst shift register: shift modes, directions
// and the controller state.
package burst_shift_register_pkg;

  localparam logic [1:0] MODE_LOGICAL = 2'd0;
  localparam logic [1:0] MODE_ROTATE  = 2'd1;
  localparam logic [1:0] MODE_ARITH   = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/burst_shift_register_shift_lane_step.sv
// One shift step of a WIDTH-bit register by a LANE-bit group: produces the
// next register value and the lane pushed out by the step.
module shift_lane_step
  import burst_shift_register_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 1
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [1:0]       mode,
  input  logic             direction,
  input  logic [LANE-1:0]  serial_in,
  output logic [WIDTH-1:0] next_val,
  output logic [LANE-1:0]  out_lane
);

  logic [LANE-1:0] fill;

  always_comb begin
    fill     = serial_in;
    out_lane = '0;
    next_val = cur;
    if (direction == DIR_RIGHT) begin
      out_lane = cur[LANE-1:0];
      case (mode)
        MODE_ROTATE: fill = cur[LANE-1:0];
        MODE_ARITH:  fill = {LANE{cur[WIDTH-1]}};
        default:     fill = serial_in;
      endcase
      next_val = {fill, cur[WIDTH-1:LANE]};
    end else begin
      out_lane = cur[WIDTH-1 -: LANE];
      // Arithmetic left shift is a plain zero fill; the reserved mode acts as logical.
      case (mode)
        MODE_ROTATE: fill = cur[WIDTH-1 -: LANE];
        MODE_ARITH:  fill = '0;
        default:     fill = serial_in;
      endcase
      next_val = {cur[WIDTH-LANE-1:0], fill};
    end
  end

endmodule

// File: rtl/burst_shift_register.sv
// Lane-wide shift register with parallel load and an autonomous N-step
// burst sequencer reporting busy and a one-cycle done pulse.
module burst_shift_register
  import burst_shift_register_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] resetValue,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             direction,
  input  logic [LANE-1:0]  serialIn,
  input  logic             loadValid,
  input  logic [WIDTH-1:0] loadData,
  output logic             loadReady,
  input  logic             startValid,
  input  logic [CNT_W-1:0] startCount,
  output logic             startReady,
  output logic [WIDTH-1:0] parallelOut,
  output logic [LANE-1:0]  serialOut,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [LANE-1:0]  serial_q, serial_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_val;
  logic [LANE-1:0]  step_out;
  logic             load_fire;
  logic             start_fire;

  shift_lane_step #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_step (
    .cur       (reg_q),
    .mode      (mode),
    .direction (direction),
    .serial_in (serialIn),
    .next_val  (step_val),
    .out_lane  (step_out)
  );

  // Load wins over start in the same cycle; a start seen with loadValid must be held.
  assign loadReady  = enable & (state_q == ST_IDLE);
  assign startReady = loadReady & ~loadValid;
  assign load_fire  = loadValid & loadReady;
  assign start_fire = startValid & startReady;

  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    serial_d    = serial_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (load_fire) begin
            reg_d = loadData;
          end else if (start_fire) begin
            if (startCount == '0) begin
              done_d = 1'b1;
            end else begin
              state_d     = ST_SHIFT;
              remaining_d = startCount;
            end
          end
        end
        ST_SHIFT: begin
          reg_d       = step_val;
          serial_d    = step_out;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      reg_q       <= resetValue;
      serial_q    <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      serial_q    <= serial_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign parallelOut = reg_q;
  assign serialOut   = serial_q;
  assign busy        = (state_q == ST_SHIFT);
  assign done        = done_q;

endmodule

// File: doc/burst_shift_register.md
Name: burst_shift_register

Overview:
Parametrised successor to the team's single-bit shift register. It shifts a WIDTH-bit register by a LANE-bit group per step and supports logical, rotate and arithmetic modes in either direction. A valid/ready load and a valid/ready "burst start" run an autonomous N-step shift sequence with busy/done status. It feeds serial links and grouper datapaths that need multi-step shifts without per-cycle control from the parent FSM.

Parameters:
WIDTH, 16, register width in bits; must be a multiple of LANE
LANE, 1, bits moved per shift step (1 <= LANE < WIDTH)
CNT_W, 8, width of the burst step count

Ports:
clock  in  1  rising-edge clock
resetN  in  1  synchronous, active-low reset
resetValue  in  WIDTH  value loaded into the register on reset
enable  in  1  global advance; low freezes all state except done clearing
mode  in  2  0 logical, 1 rotate, 2 arithmetic, 3 reserved (treated as logical)
direction  in  1  1 = right (toward bit 0), 0 = left
serialIn  in  LANE  fill lane for logical mode
loadValid  in  1  parallel load request
loadData  in  WIDTH  parallel load value
loadReady  out  1  load accepted this cycle when high with loadValid
startValid  in  1  burst start request
startCount  in  CNT_W  number of shift steps N
startReady  out  1  start accepted when high with startValid
parallelOut  out  WIDTH  register contents
serialOut  out  LANE  lane shifted out by the most recent step
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (resetN low at a clock edge): parallelOut=resetValue, serialOut=0, state IDLE, remaining count 0, busy=0, done=0. Reset overrides everything, including mid-burst; an aborted burst produces no done pulse.
- States: IDLE and SHIFT. busy = (state==SHIFT).
- loadReady = enable & IDLE. startReady = enable & IDLE & !loadValid. Load has priority over start when both are valid in the same cycle; the start is not accepted and must be held.
- Load accept edge: parallelOut=loadData. serialOut, state and done are unchanged, except that done clears as stated below.
- Start accept edge E0 with N>0: state goes to SHIFT with remaining=N. Each enabled edge in SHIFT performs one step and decrements remaining. On the edge that takes remaining from 1 to 0: state goes to IDLE and done=1. Net effect: N steps on edges E1..EN, busy high E0..EN, done high for the cycle after EN.
- Start with N=0: no shift and no busy; done=1 on the cycle after E0.
- done clears on the next clock edge regardless of enable, so it is never wider than one cycle.
- enable low: register, state, count and serialOut hold. loadReady and startReady are 0.
- Step function, right direction:
  - serialOut gets the old bits [LANE-1:0].
  - Register shifts down by LANE.
  - Top lane fill: serialIn (logical), old low lane (rotate), or LANE copies of the old MSB (arithmetic).
- Step function, left direction:
  - serialOut gets the old top lane.
  - Register shifts up by LANE.
  - Bottom lane fill: serialIn (logical), old top lane (rotate), or zeros (arithmetic).
- mode, direction and serialIn are sampled on every step edge and may change mid-burst.
- loadValid and startValid are ignored while busy.

Decomposition:
- Shared package holds:
  - mode encodings MODE_LOGICAL, MODE_ROTATE, MODE_ARITH
  - direction constants DIR_LEFT and DIR_RIGHT
  - the IDLE/SHIFT state encoding
- One combinational sub-module, shift_lane_step (parameters WIDTH and LANE), computes the next register value and the out-lane from the current value, mode, direction and serialIn. The top level holds the FSM, counter and registers.

Test Plan:
All tests use WIDTH=16, LANE=4.
- Reset: resetValue=16'hA5A5, resetN low for one edge -> parallelOut=16'hA5A5, serialOut=0, busy=0, done=0, loadReady=1.
- Logical right burst: load 16'h1234, start N=2, mode 0, direction 1, serialIn=4'hF -> parallelOut=16'hFF12, serialOut=4'h3. busy high for 2 cycles, then done high for exactly 1 cycle.
- Rotate left, N=1, from 16'h1234 -> 16'h2341, serialOut=4'h1. Rotate right, N=4, from 16'h1234 -> 16'h1234.
- Arithmetic:
  - right, N=1, from 16'h8000 -> 16'hF800
  - left, N=1, from 16'h8001 -> 16'h0010, serialOut=4'h8
- Stall and priority:
  - start N=4, drop enable for 3 cycles mid-burst -> done arrives 3 cycles later than the unstalled case and is still 1 cycle wide
  - loadValid while busy -> no effect
  - loadValid and startValid together in IDLE -> load taken, start accepted the next cycle
- Abort and zero-length:
  - resetN low at step 2 of an N=4 burst -> parallelOut=resetValue, busy=0, no done pulse
  - start N=0 -> done pulse, parallelOut unchanged
